xpb_lut_bank: RTL and testbench
===============================

Name: xpb_lut_bank

Overview:
- Runtime-loadable, multi-channel successor to the hard-coded xpb constant tables used by the modular squaring reduction.
- Holds 2^IDX_BITS reduction constants of DATA_W bits each. Entry 0 is fixed at zero; all other entries are loaded serially over a narrow beat interface.
- Serves NUM_CH independent lookup channels with fixed 2-cycle latency.
- Lets one bitstream serve any modulus without regenerating per-modulus case tables.

Parameters:
- DATA_W, 1024, width of each table entry.
- IDX_BITS, 5, index width; DEPTH = 2^IDX_BITS.
- NUM_CH, 4, number of parallel lookup channels.
- LOAD_W, 64, load beat width; DATA_W must be an integer multiple of LOAD_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- load_start  in  1  pulse; begins or restarts a table load
- ld_valid  in  1  load beat valid
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready
- ld_data  in  LOAD_W  load beat payload
- table_ready  out  1  table fully loaded and usable
- rd_valid_in  in  NUM_CH  per-channel lookup request
- rd_idx  in  NUM_CH*IDX_BITS  per-channel index; channel c uses bits [c*IDX_BITS +: IDX_BITS]
- rd_valid_out  out  NUM_CH  per-channel result valid
- rd_data  out  NUM_CH*DATA_W  per-channel result; channel c uses bits [c*DATA_W +: DATA_W]
- rd_err  out  NUM_CH  per-channel: lookup was accepted while table_ready=0

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values:
  - ld_ready=0, table_ready=0.
  - rd_valid_out=0, rd_data=0, rd_err=0.
  - FSM in IDLE; beat and entry counters cleared.
  - Stored table contents are not cleared.
- Constants: BEATS = DATA_W/LOAD_W; total load length = (DEPTH-1)*BEATS beats. Defaults give 16 beats per entry and 496 beats total.
- Load FSM, IDLE:
  - ld_ready=0.
  - load_start moves to LOAD, with entry counter = 1 and beat counter = 0.
- Load FSM, LOAD:
  - ld_ready=1 and table_ready=0.
  - Each accepted beat writes ld_data into bits [beat*LOAD_W +: LOAD_W] of the current entry. Beats arrive LSB-first.
  - Beat counter wraps at BEATS-1, then the entry counter increments.
  - Acceptance of the beat for entry DEPTH-1, beat BEATS-1 moves to DONE on the next edge.
- Load FSM, DONE:
  - table_ready=1 and ld_ready=0.
  - load_start returns to LOAD, clears table_ready the next cycle and restarts at entry 1.
- load_start while in LOAD:
  - Restarts at entry 1, beat 0.
  - A beat presented in the same cycle is discarded.
- ld_valid while ld_ready=0: ignored.
- Entry 0 is never written and always reads as zero.
- Lookup pipeline, per channel, no backpressure:
  - Cycle T: rd_valid_in[c] with an index is accepted. Index, valid and ~table_ready are registered.
  - Cycle T+1: table read.
  - rd_data, rd_valid_out and rd_err are registered and appear at T+2.
- Channel independence: channels may use the same index in the same cycle with no conflict.
- Lookup while table_ready=0 at acceptance: rd_valid_out=1, rd_err=1, rd_data=0.
- When rd_valid_out=0: rd_data holds its previous value and rd_err=0.
- Back-to-back lookups every cycle give full throughput.
- Reset mid-load: FSM returns to IDLE and table_ready=0. A new load_start is required.
- Reset mid-lookup: in-flight results are dropped and rd_valid_out=0 the next cycle.
- Write during DONE: not possible, because a table update always passes through LOAD with table_ready=0.
- Implementation: the table is a register array. No RAM inference is required.

Optional Feature:
- Macro: XPB_LUT_CHECKSUM_EN.
- When defined:
  - Adds output port ld_checksum [LOAD_W], reset to 0.
  - load_start clears ld_checksum to 0.
  - Each accepted beat updates ld_checksum to ld_checksum XOR ld_data.
  - The value is stable once table_ready=1, for software cross-check of the load.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then lookup on ch0 with idx=3 -> at T+2: rd_valid_out[0]=1, rd_err[0]=1, rd_data=0. ld_ready=0 and table_ready=0.
- load_start, then 496 beats with entry k, beat b = {k[15:0], b[15:0], 32'hA5A5_0000} -> table_ready=1 exactly one cycle after the last beat. Lookup on all channels of idx 1, 17, 31, 0 returns the matching entries, with entry 0 = 0, rd_err=0 and latency 2.
- Same load with ld_valid toggled randomly, about 50% -> identical table contents. No beat is lost or duplicated.
- load_start issued after 100 beats, then a full 496-beat load -> contents equal the second load. table_ready stays 0 until its final beat.
- After load, all 4 channels request idx 5 every cycle for 20 cycles -> 20 consecutive valid results per channel with identical data.
- With XPB_LUT_CHECKSUM_EN, all beats = 64'h1 -> ld_checksum = 0 after 496 beats. A single beat of 64'hFF among zeros -> ld_checksum = 64'hFF.

Source files
------------

// File: rtl/xpb_lut_bank.sv
// Runtime-loadable reduction-constant table with NUM_CH independent 2-cycle lookup channels.
// Optional XPB_LUT_CHECKSUM_EN adds an XOR checksum of all accepted load beats.
module xpb_lut_bank #(
  parameter int DATA_W   = 1024,
  parameter int IDX_BITS = 5,
  parameter int NUM_CH   = 4,
  parameter int LOAD_W   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [LOAD_W-1:0]            ld_data,
  output logic                         table_ready,
  input  logic [NUM_CH-1:0]            rd_valid_in,
  input  logic [NUM_CH*IDX_BITS-1:0]   rd_idx,
  output logic [NUM_CH-1:0]            rd_valid_out,
  output logic [NUM_CH*DATA_W-1:0]     rd_data,
  output logic [NUM_CH-1:0]            rd_err
`ifdef XPB_LUT_CHECKSUM_EN
  ,
  output logic [LOAD_W-1:0]            ld_checksum
`endif
);

  localparam int DEPTH     = 2 ** IDX_BITS;
  localparam int BEATS     = DATA_W / LOAD_W;
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_BITS-1:0] BEAT_LAST  = BEAT_BITS'(BEATS - 1);
  localparam logic [IDX_BITS-1:0]  ENTRY_LAST = IDX_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_r, state_nx;
  logic [IDX_BITS-1:0]   entry_r, entry_nx;
  logic [BEAT_BITS-1:0]  beat_r, beat_nx;
  logic                  wr_en_s;

  // Entry 0 has no storage: it is hard-wired to zero on the read side.
  logic [DATA_W-1:0]     table_r [1:DEPTH-1];

  logic [NUM_CH-1:0]          vld_s1_r;
  logic [NUM_CH-1:0]          err_s1_r;
  logic [NUM_CH*IDX_BITS-1:0] idx_s1_r;
  logic [DATA_W-1:0]          rd_word_s [NUM_CH];

  // Load FSM state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      entry_r     <= '0;
      beat_r      <= '0;
      ld_ready    <= 1'b0;
      table_ready <= 1'b0;
    end else begin
      state_r     <= state_nx;
      entry_r     <= entry_nx;
      beat_r      <= beat_nx;
      ld_ready    <= (state_nx == ST_LOAD);
      table_ready <= (state_nx == ST_DONE);
    end
  end

  // Next-state and beat-acceptance decode; load_start always wins over a beat.
  always_comb begin
    state_nx = state_r;
    entry_nx = entry_r;
    beat_nx  = beat_r;
    wr_en_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_nx = ST_LOAD;
          entry_nx = IDX_BITS'(1);
          beat_nx  = '0;
        end else begin
          state_nx = state_r;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          entry_nx = IDX_BITS'(1);
          beat_nx  = '0;
        end else if (ld_valid) begin
          wr_en_s = 1'b1;
          if (beat_r == BEAT_LAST) begin
            beat_nx = '0;
            if (entry_r == ENTRY_LAST) begin
              state_nx = ST_DONE;
            end else begin
              entry_nx = entry_r + IDX_BITS'(1);
            end
          end else begin
            beat_nx = beat_r + BEAT_BITS'(1);
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Table storage: LSB-first beat writes into the current entry, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_r == BEAT_BITS'(b)) begin
          table_r[entry_r][b*LOAD_W +: LOAD_W] <= ld_data;
        end
      end
    end
  end

  // Stage-1 table read; an error lookup or index 0 yields zero.
  always_comb begin
    rd_word_s = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      if (err_s1_r[c] || (idx_s1_r[c*IDX_BITS +: IDX_BITS] == '0)) begin
        rd_word_s[c] = '0;
      end else begin
        rd_word_s[c] = table_r[idx_s1_r[c*IDX_BITS +: IDX_BITS]];
      end
    end
  end

  // Two-stage lookup pipeline; rd_data holds when no result is produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_s1_r     <= '0;
      err_s1_r     <= '0;
      idx_s1_r     <= '0;
      rd_valid_out <= '0;
      rd_err       <= '0;
      rd_data      <= '0;
    end else begin
      vld_s1_r     <= rd_valid_in;
      err_s1_r     <= {NUM_CH{~table_ready}};
      idx_s1_r     <= rd_idx;
      rd_valid_out <= vld_s1_r;
      rd_err       <= vld_s1_r & err_s1_r;
      for (int c = 0; c < NUM_CH; c++) begin
        if (vld_s1_r[c]) begin
          rd_data[c*DATA_W +: DATA_W] <= rd_word_s[c];
        end
      end
    end
  end

`ifdef XPB_LUT_CHECKSUM_EN
  // Running XOR of accepted beats, cleared by every load_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_checksum <= '0;
    end else if (load_start) begin
      ld_checksum <= '0;
    end else if (wr_en_s) begin
      ld_checksum <= ld_checksum ^ ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Directed testbench for xpb_lut_bank with a lookup scoreboard and load model.
// Checksum checks are compiled in when XPB_LUT_CHECKSUM_EN is defined.
module tb_xpb_lut_bank;
  localparam int DATA_W = 1024, IDX_BITS = 5, NUM_CH = 4, LOAD_W = 64;
  localparam int DEPTH = 32, BEATS = 16, TOTAL = 496;

  logic                        clk = 1'b0;
  logic                        reset, load_start, ld_valid;
  logic                        ld_ready, table_ready;
  logic [LOAD_W-1:0]           ld_data;
  logic [NUM_CH-1:0]           rd_valid_in, rd_valid_out, rd_err;
  logic [NUM_CH*IDX_BITS-1:0]  rd_idx;
  logic [NUM_CH*DATA_W-1:0]    rd_data;
`ifdef XPB_LUT_CHECKSUM_EN
  logic [LOAD_W-1:0]           ld_checksum;
`endif

  always #5 clk = ~clk;

  xpb_lut_bank #(.DATA_W(DATA_W), .IDX_BITS(IDX_BITS), .NUM_CH(NUM_CH), .LOAD_W(LOAD_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .table_ready(table_ready),
    .rd_valid_in(rd_valid_in), .rd_idx(rd_idx), .rd_valid_out(rd_valid_out),
    .rd_data(rd_data), .rd_err(rd_err)
`ifdef XPB_LUT_CHECKSUM_EN
    , .ld_checksum(ld_checksum)
`endif
  );

  typedef struct {
    int                       due;
    logic [NUM_CH-1:0]        v;
    logic [NUM_CH-1:0]        e;
    logic [NUM_CH*DATA_W-1:0] d;
  } exp_t;

  exp_t              sbq[$];
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] prev_d [NUM_CH];
  logic [LOAD_W-1:0] csum;
  bit                model_ready;
  int                cyc, checks, errors;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare lookup outputs against the scoreboard.
  task automatic step();
    exp_t x;
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      x = sbq.pop_front();
      chk("rd_valid_out", DATA_W'(rd_valid_out), DATA_W'(x.v));
      chk("rd_err", DATA_W'(rd_err), DATA_W'(x.e));
      for (int c = 0; c < NUM_CH; c++)
        chk($sformatf("rd_data_ch%0d", c), rd_data[c*DATA_W +: DATA_W], x.d[c*DATA_W +: DATA_W]);
    end else begin
      chk("idle_rd_valid_out", DATA_W'(rd_valid_out), '0);
      chk("idle_rd_err", DATA_W'(rd_err), '0);
    end
  endtask

  function automatic logic [LOAD_W-1:0] gen(input int mode, input logic [31:0] salt,
                                            input logic [15:0] k, input logic [15:0] b, input int n);
    case (mode)
      1:       gen = 64'h0000_0000_0000_0001;
      2:       gen = (n == 200) ? 64'h0000_0000_0000_00FF : 64'h0;
      default: gen = {k, b, 32'hA5A5_0000} ^ {32'h0, salt};
    endcase
  endfunction

  // Drive one lookup cycle and push the expected result two cycles later.
  task automatic issue(input logic [NUM_CH-1:0] v, input logic [NUM_CH*IDX_BITS-1:0] idx);
    exp_t x;
    rd_valid_in = v;
    rd_idx      = idx;
    x.due = cyc + 2;
    x.v   = v;
    x.e   = model_ready ? '0 : v;
    for (int c = 0; c < NUM_CH; c++) begin
      if (v[c]) prev_d[c] = model_ready ? model[idx[c*IDX_BITS +: IDX_BITS]] : '0;
      x.d[c*DATA_W +: DATA_W] = prev_d[c];
    end
    sbq.push_back(x);
    step();
    rd_valid_in = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step();
  endtask

  // Every index across all channels, rotating channel assignment.
  task automatic sweep();
    logic [NUM_CH*IDX_BITS-1:0] iv;
    for (int i = 0; i < DEPTH / NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) iv[c*IDX_BITS +: IDX_BITS] = IDX_BITS'((i * NUM_CH + c * 5) % DEPTH);
      issue('1, iv);
    end
    drain();
  endtask

  task automatic load(input int mode, input logic [31:0] salt, input int nbeats, input bit rnd, input bit junk);
    int k, b, cnt, guard;
    bit v, rdy;
    logic [LOAD_W-1:0] d;
    load_start = 1'b1;
    ld_valid   = junk;
    ld_data    = 64'hDEAD_BEEF_DEAD_BEEF;
    model_ready = 1'b0;
    csum = '0;
    step();
    load_start = 1'b0;
    ld_valid   = 1'b0;
    chk("load_table_ready", DATA_W'(table_ready), '0);
    chk("load_ld_ready", DATA_W'(ld_ready), DATA_W'(1));
    k = 1; b = 0; cnt = 0; guard = 0;
    while (cnt < nbeats && guard < 20000) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      d = gen(mode, salt, 16'(k), 16'(b), cnt);
      ld_valid = v;
      ld_data  = d;
      rdy = ld_ready;
      step();
      guard++;
      if (v) begin
        chk("beat_ld_ready", DATA_W'(rdy), DATA_W'(1));
        model[k][b*LOAD_W +: LOAD_W] = d;
        csum ^= d;
        cnt++;
        if (b == BEATS - 1) begin b = 0; k++; end else b++;
        if (cnt == TOTAL) begin
          chk("done_table_ready", DATA_W'(table_ready), DATA_W'(1));
          chk("done_ld_ready", DATA_W'(ld_ready), '0);
        end else begin
          chk("mid_table_ready", DATA_W'(table_ready), '0);
        end
      end
    end
    ld_valid = 1'b0;
    if (guard >= 20000) chk("load_timeout", DATA_W'(cnt), DATA_W'(nbeats));
    if (nbeats == TOTAL) begin
      model_ready = 1'b1;
`ifdef XPB_LUT_CHECKSUM_EN
      chk("ld_checksum", DATA_W'(ld_checksum), DATA_W'(csum));
`endif
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    rd_valid_in = '0; rd_idx = '0;
    cyc = 0; checks = 0; errors = 0; model_ready = 1'b0; csum = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int c = 0; c < NUM_CH; c++) prev_d[c] = '0;

    step(); step();
    chk("rst_ld_ready", DATA_W'(ld_ready), '0);
    chk("rst_table_ready", DATA_W'(table_ready), '0);
    chk("rst_rd_data", rd_data[DATA_W-1:0], '0);
    reset = 1'b0;
    step();

    // Lookup before any load: error result with zero data.
    issue(4'b0001, 20'd3);
    drain();
    chk("preload_ld_ready", DATA_W'(ld_ready), '0);
    chk("preload_table_ready", DATA_W'(table_ready), '0);

    // Contiguous load, then targeted lookups and a full sweep.
    load(0, 32'h0, TOTAL, 1'b0, 1'b0);
    issue(4'hF, {5'd0, 5'd31, 5'd17, 5'd1});
    issue(4'hF, {5'd1, 5'd0, 5'd31, 5'd17});
    drain();
    sweep();

    // Interrupted load followed by a distinct full load; restart beat is junk.
    load(0, 32'h1111_2222, 100, 1'b0, 1'b0);
    load(0, 32'h3C3C_5A5A, TOTAL, 1'b0, 1'b1);
    sweep();

    // Randomly gapped load of the original pattern.
    load(0, 32'h0, TOTAL, 1'b1, 1'b0);
    sweep();

    // Full-throughput lookups on a shared index.
    for (int i = 0; i < 20; i++) issue(4'hF, {4{5'd5}});
    drain();

    // Mixed valid channels: inactive channels hold their previous data.
    issue(4'b0101, {5'd9, 5'd30, 5'd2, 5'd0});
    issue(4'b1010, {5'd12, 5'd3, 5'd0, 5'd7});
    drain();

`ifdef XPB_LUT_CHECKSUM_EN
    load(1, 32'h0, TOTAL, 1'b0, 1'b0);
    chk("csum_all_ones", DATA_W'(ld_checksum), '0);
    load(2, 32'h0, TOTAL, 1'b0, 1'b0);
    chk("csum_single_ff", DATA_W'(ld_checksum), DATA_W'(64'hFF));
    sweep();
`endif

    // Reset with lookups in flight.
    issue(4'hF, {4{5'd5}});
    reset = 1'b1;
    sbq.delete();
    for (int c = 0; c < NUM_CH; c++) prev_d[c] = '0;
    model_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rst_flush_table_ready", DATA_W'(table_ready), '0);
    chk("rst_flush_rd_data", rd_data[DATA_W-1:0], '0);

    // Reset during a load: back to idle, beats ignored without load_start.
    load(0, 32'h0, 10, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ld_valid = 1'b1;
    step(); step();
    chk("rst_load_ld_ready", DATA_W'(ld_ready), '0);
    chk("rst_load_table_ready", DATA_W'(table_ready), '0);
    ld_valid = 1'b0;
    issue(4'b1000, {5'd4, 15'd0});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
